fetch_queue: RTL and testbench

Parametrised instruction prefetch queue between the multi-cycle core's fetch logic and the shared memory port (SPI SRAM / peripherals). It replaces single-word, fetch-on-demand behaviour. It keeps up to DEPTH instruction words (with their PCs) buffered ahead of execution and drops stale fetches on redirect (branch, jump, ISR entry, mret). It yields the memory port whenever the core requests a data access.

---
 rtl/fetch_queue.sv | 161 ++++++++++++++++
 tb/tb_fetch_queue.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between the core's fetch logic and
// the shared memory port. Buffers up to DEPTH {iword, pc, fault} entries ahead
// of execution, keeps at most one fetch outstanding, drops stale responses on
// redirect and yields the memory port whenever the core wants a data access.
//
// Handshakes:
//   - Dequeue: an entry is popped on a rising edge where deq_valid && deq_ready.
//     deq_valid depends only on registered state; deq_ready may depend on deq_*.
//   - Memory: mem_ce is a one-cycle request pulse carrying mem_addr. The matching
//     response is the next mem_valid pulse. mem_valid with no fetch outstanding
//     belongs to a data access and is ignored.
module fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 23,
    parameter int                XLEN     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prefetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              data_req,
    input  logic              deq_ready,
    output logic              deq_valid,
    output logic [XLEN-1:0]   deq_iword,
    output logic [ADDR_W-1:0] deq_pc,
    output logic              deq_fault,
    output logic              fetch_idle,
    output logic              mem_ce,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_busy,
    input  logic              mem_valid,
    input  logic [XLEN-1:0]   mem_dataout,
    input  logic              mem_fault
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry storage
    logic [XLEN-1:0]   iword_q [DEPTH];
    logic [ADDR_W-1:0] pc_q    [DEPTH];
    logic              fault_q [DEPTH];

    // Pointers, occupancy and fetch bookkeeping
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic              outstanding;
    logic              drop;
    logic              halt;

    logic              credit;
    logic              issue;
    logic              resp_fire;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] redirect_aligned;

    // Redirect targets are word aligned; the low two address bits carry no meaning.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_aligned     = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Fetch credit: prefetch fills the queue, legacy mode waits for it to drain
    always_comb begin
        credit = 1'b0;
        if (prefetch_en) begin
            credit = (count < CNT_W'(DEPTH));
        end else begin
            credit = (count == '0);
        end
    end

    // Credit is checked before issue, so a response always finds a free slot.
    assign issue     = !reset && !redirect && !outstanding && !mem_busy
                       && !data_req && !halt && credit;
    assign resp_fire = mem_valid && outstanding;
    assign wr_en     = resp_fire && !drop && !redirect;
    assign rd_en     = deq_valid && deq_ready && !redirect;

    assign mem_ce     = issue;
    assign mem_addr   = fetch_pc;
    assign fetch_idle = !outstanding;
    assign deq_valid  = (count != '0);
    assign deq_iword  = iword_q[head];
    assign deq_pc     = pc_q[head];
    assign deq_fault  = fault_q[head];

    // Write accepted responses into the entry at tail
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                iword_q[i] <= '0;
                pc_q[i]    <= '0;
                fault_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            iword_q[tail] <= mem_dataout;
            pc_q[tail]    <= resp_pc;
            fault_q[tail] <= mem_fault;
        end
    end

    // Control state: redirect flushes everything, otherwise issue/respond/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            halt        <= 1'b0;
        end else if (redirect) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            halt     <= 1'b0;
            fetch_pc <= redirect_aligned;
            // A fetch still in flight belongs to the old stream: mark it for discard
            // unless its response is arriving right now, in which case it dies here.
            if (resp_fire) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end else begin
                drop <= outstanding;
            end
        end else begin
            if (issue) begin
                outstanding <= 1'b1;
                resp_pc     <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(4);
            end
            if (resp_fire) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
                // A faulting fetch stops the stream until the core redirects.
                if (!drop && mem_fault) begin
                    halt <= 1'b1;
                end
            end
            if (wr_en) begin
                tail <= tail + PTR_W'(1);
            end
            if (rd_en) begin
                head <= head + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a fixed-latency memory
// responder, per-scenario tasks and an expected-address queue.
module tb_fetch_queue;

  localparam int ADDR_W = 23;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int LAT    = 3;

  logic              clk;
  logic              reset;
  logic              prefetch_en;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              data_req;
  logic              deq_ready;
  logic              deq_valid;
  logic [XLEN-1:0]   deq_iword;
  logic [ADDR_W-1:0] deq_pc;
  logic              deq_fault;
  logic              fetch_idle;
  logic              mem_ce;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_busy;
  logic              mem_valid;
  logic [XLEN-1:0]   mem_dataout;
  logic              mem_fault;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] addr_log[$];
  int                cyc_log[$];

  // memory responder state
  logic              fault_en;
  logic [ADDR_W-1:0] fault_addr;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  int                lat_cnt;

  fetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .XLEN(XLEN), .RESET_PC('0)
  ) dut (
    .clk(clk), .reset(reset), .prefetch_en(prefetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .data_req(data_req), .deq_ready(deq_ready),
    .deq_valid(deq_valid), .deq_iword(deq_iword), .deq_pc(deq_pc),
    .deq_fault(deq_fault), .fetch_idle(fetch_idle), .mem_ce(mem_ce),
    .mem_addr(mem_addr), .mem_busy(mem_busy), .mem_valid(mem_valid),
    .mem_dataout(mem_dataout), .mem_fault(mem_fault)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    reset = 1'b1; prefetch_en = 1'b1; redirect = 1'b0; redirect_pc = '0;
    data_req = 1'b0; deq_ready = 1'b0; mem_busy = 1'b0;
    mem_valid = 1'b0; mem_dataout = '0; mem_fault = 1'b0;
    fault_en = 1'b0; fault_addr = '0; pend = 1'b0; pend_addr = '0; lat_cnt = 0;
  end

  function automatic logic [XLEN-1:0] data_of(input logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 ^ {9'd0, a};
  endfunction

  // memory model: responds LAT cycles after each mem_ce, sampled at negedge
  always @(negedge clk) begin
    mem_valid = 1'b0;
    mem_fault = 1'b0;
    if (pend) begin
      if (lat_cnt <= 1) begin
        mem_valid   = 1'b1;
        mem_dataout = data_of(pend_addr);
        mem_fault   = fault_en && (pend_addr == fault_addr);
        pend        = 1'b0;
      end else begin
        lat_cnt = lat_cnt - 1;
      end
    end
    if (mem_ce === 1'b1) begin
      addr_log.push_back(mem_addr);
      cyc_log.push_back(cyc);
      pend      = 1'b1;
      pend_addr = mem_addr;
      lat_cnt   = LAT;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset_deq_valid: got %0b expected 0", deq_valid); end
    checks++; if (deq_fault !== 1'b0) begin errors++; $display("FAIL reset_deq_fault: got %0b expected 0", deq_fault); end
    checks++; if (deq_iword !== 32'h0) begin errors++; $display("FAIL reset_deq_iword: got %h expected 0", deq_iword); end
    checks++; if (deq_pc !== 23'h0) begin errors++; $display("FAIL reset_deq_pc: got %h expected 0", deq_pc); end
    checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL reset_mem_ce: got %0b expected 0", mem_ce); end
    checks++; if (fetch_idle !== 1'b1) begin errors++; $display("FAIL reset_fetch_idle: got %0b expected 1", fetch_idle); end
    step();
    addr_log.delete(); cyc_log.delete();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h0) begin errors++; $display("FAIL first_ce: got ce=%0b addr=%h expected ce=1 addr=0", mem_ce, mem_addr); end
  endtask

  task automatic test_prefetch_fill();
    steps(25);
    exp_q = '{23'h0, 23'h4, 23'h8, 23'hC};
    checks++; if (addr_log.size() !== exp_q.size()) begin errors++; $display("FAIL fill_ce_count: got %0d expected %0d", addr_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < addr_log.size()) begin
        checks++; if (addr_log[i] !== exp_q[i]) begin errors++; $display("FAIL fill_addr_%0d: got %h expected %h", i, addr_log[i], exp_q[i]); end
      end
    end
    for (int i = 1; i < cyc_log.size(); i++) begin
      checks++; if (cyc_log[i] - cyc_log[i-1] !== LAT + 1) begin errors++; $display("FAIL back_to_back_%0d: got spacing %0d expected %0d", i, cyc_log[i] - cyc_log[i-1], LAT + 1); end
    end
    @(negedge clk);
    checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL fill_full_ce: got %0b expected 0", mem_ce); end
    checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", dut.count); end
    checks++; if (deq_valid !== 1'b1 || deq_pc !== 23'h0) begin errors++; $display("FAIL fill_head: got valid=%0b pc=%h expected valid=1 pc=0", deq_valid, deq_pc); end
    checks++; if (deq_iword !== data_of(23'h0)) begin errors++; $display("FAIL fill_iword: got %h expected %h", deq_iword, data_of(23'h0)); end
  endtask

  task automatic test_redirect_outstanding();
    int n;
    step();
    addr_log.delete();
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    @(negedge clk);
    checks++; if (deq_pc !== 23'h4) begin errors++; $display("FAIL pop_head_pc: got %h expected 4", deq_pc); end
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h10) begin errors++; $display("FAIL refill_ce: got ce=%0b addr=%h expected ce=1 addr=10", mem_ce, mem_addr); end
    step();
    redirect = 1'b1; redirect_pc = 23'h100;
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %0b expected 0", deq_valid); end
    checks++; if (fetch_idle !== 1'b0) begin errors++; $display("FAIL redir_keeps_outstanding: got idle=%0b expected 0", fetch_idle); end
    n = 0;
    while (deq_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL redir_timeout: got deq_valid=%0b expected 1", deq_valid); end
    checks++; if (deq_pc !== 23'h100) begin errors++; $display("FAIL redir_first_pc: got %h expected 100", deq_pc); end
    checks++; if (deq_iword !== data_of(23'h100)) begin errors++; $display("FAIL redir_first_iword: got %h expected %h", deq_iword, data_of(23'h100)); end
    checks++;
    if (addr_log.size() < 2) begin
      errors++; $display("FAIL redir_ce_log: got %0d entries expected at least 2", addr_log.size());
    end else if (addr_log[0] !== 23'h10 || addr_log[1] !== 23'h100) begin
      errors++; $display("FAIL redir_ce_log: got %h,%h expected 10,100", addr_log[0], addr_log[1]);
    end
  endtask

  task automatic test_redirect_with_deq();
    int n;
    steps(20);
    addr_log.delete();
    redirect = 1'b1; redirect_pc = 23'h102; deq_ready = 1'b1;
    step();
    redirect = 1'b0; deq_ready = 1'b0;
    @(negedge clk);
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL redir_deq_valid: got %0b expected 0", deq_valid); end
    checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL redir_deq_count: got %0d expected 0", dut.count); end
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h100) begin errors++; $display("FAIL redir_deq_ce: got ce=%0b addr=%h expected ce=1 addr=100", mem_ce, mem_addr); end
    n = 0;
    while (deq_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (deq_valid !== 1'b1 || deq_pc !== 23'h100) begin errors++; $display("FAIL redir_deq_head: got valid=%0b pc=%h expected valid=1 pc=100", deq_valid, deq_pc); end
  endtask

  task automatic test_data_req();
    logic exp_idle;
    steps(20);
    redirect = 1'b1; redirect_pc = 23'h200;
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h200) begin errors++; $display("FAIL dreq_first_ce: got ce=%0b addr=%h expected ce=1 addr=200", mem_ce, mem_addr); end
    step();
    data_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_idle = (k >= 4);
      checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL dreq_ce_%0d: got %0b expected 0", k, mem_ce); end
      checks++; if (fetch_idle !== exp_idle) begin errors++; $display("FAIL dreq_idle_%0d: got %0b expected %0b", k, fetch_idle, exp_idle); end
      step();
    end
    data_req = 1'b0; mem_busy = 1'b1;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL busy_ce: got %0b expected 0", mem_ce); end
    checks++; if (dut.count !== 3'd1 || deq_pc !== 23'h200) begin errors++; $display("FAIL dreq_queue: got count=%0d pc=%h expected count=1 pc=200", dut.count, deq_pc); end
    step();
    mem_busy = 1'b0;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h204) begin errors++; $display("FAIL dreq_resume: got ce=%0b addr=%h expected ce=1 addr=204", mem_ce, mem_addr); end
  endtask

  task automatic test_fault();
    logic [ADDR_W-1:0] e_pc;
    logic              e_fault;
    steps(20);
    fault_en = 1'b1; fault_addr = 23'h8;
    addr_log.delete();
    redirect = 1'b1; redirect_pc = 23'h0;
    step();
    redirect = 1'b0;
    steps(30);
    exp_q = '{23'h0, 23'h4, 23'h8};
    checks++; if (addr_log.size() !== exp_q.size()) begin errors++; $display("FAIL fault_ce_count: got %0d expected %0d", addr_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < addr_log.size()) begin
        checks++; if (addr_log[i] !== exp_q[i]) begin errors++; $display("FAIL fault_addr_%0d: got %h expected %h", i, addr_log[i], exp_q[i]); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e_pc = ADDR_W'(4 * i);
      e_fault = (i == 2);
      checks++; if (deq_valid !== 1'b1 || deq_pc !== e_pc) begin errors++; $display("FAIL fault_pop_pc_%0d: got valid=%0b pc=%h expected valid=1 pc=%h", i, deq_valid, deq_pc, e_pc); end
      checks++; if (deq_fault !== e_fault) begin errors++; $display("FAIL fault_pop_flag_%0d: got %0b expected %0b", i, deq_fault, e_fault); end
      step();
      deq_ready = 1'b1;
      step();
      deq_ready = 1'b0;
    end
    steps(10);
    @(negedge clk);
    checks++; if (addr_log.size() !== 3) begin errors++; $display("FAIL fault_halt_log: got %0d entries expected 3", addr_log.size()); end
    checks++; if (mem_ce !== 1'b0 || deq_valid !== 1'b0) begin errors++; $display("FAIL fault_halt_state: got ce=%0b valid=%0b expected 0,0", mem_ce, deq_valid); end
    step();
    fault_en = 1'b0;
    redirect = 1'b1; redirect_pc = 23'h40;
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h40) begin errors++; $display("FAIL fault_resume: got ce=%0b addr=%h expected ce=1 addr=40", mem_ce, mem_addr); end
  endtask

  task automatic test_legacy_wrap();
    steps(20);
    prefetch_en = 1'b0;
    addr_log.delete();
    redirect = 1'b1; redirect_pc = 23'h80;
    step();
    redirect = 1'b0;
    steps(10);
    checks++; if (addr_log.size() !== 1) begin errors++; $display("FAIL legacy_one_fetch: got %0d fetches expected 1", addr_log.size()); end
    @(negedge clk);
    checks++; if (deq_pc !== 23'h80 || dut.count !== 3'd1) begin errors++; $display("FAIL legacy_entry: got pc=%h count=%0d expected pc=80 count=1", deq_pc, dut.count); end
    checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL legacy_hold: got ce=%0b expected 0", mem_ce); end
    step();
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h84) begin errors++; $display("FAIL legacy_next: got ce=%0b addr=%h expected ce=1 addr=84", mem_ce, mem_addr); end
    steps(10);
    checks++; if (addr_log.size() !== 2) begin errors++; $display("FAIL legacy_two_fetch: got %0d fetches expected 2", addr_log.size()); end
    prefetch_en = 1'b1;
    redirect = 1'b1; redirect_pc = 23'h7FFFFC;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL redirect_cycle_ce: got %0b expected 0", mem_ce); end
    step();
    redirect = 1'b0; prefetch_en = 1'b0;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h7FFFFC) begin errors++; $display("FAIL wrap_top: got ce=%0b addr=%h expected ce=1 addr=7ffffc", mem_ce, mem_addr); end
    steps(6);
    @(negedge clk);
    checks++; if (deq_valid !== 1'b1 || deq_pc !== 23'h7FFFFC) begin errors++; $display("FAIL wrap_entry: got valid=%0b pc=%h expected valid=1 pc=7ffffc", deq_valid, deq_pc); end
    step();
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h0) begin errors++; $display("FAIL wrap_zero: got ce=%0b addr=%h expected ce=1 addr=0", mem_ce, mem_addr); end
  endtask

  task automatic test_reset_mid();
    steps(10);
    prefetch_en = 1'b1;
    redirect = 1'b1; redirect_pc = 23'h300;
    step();
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h300) begin errors++; $display("FAIL rmid_ce: got ce=%0b addr=%h expected ce=1 addr=300", mem_ce, mem_addr); end
    step();
    reset = 1'b1; data_req = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (fetch_idle !== 1'b1 || deq_valid !== 1'b0) begin errors++; $display("FAIL rmid_state: got idle=%0b valid=%0b expected 1,0", fetch_idle, deq_valid); end
    checks++; if (deq_pc !== 23'h0 || deq_iword !== 32'h0 || deq_fault !== 1'b0) begin errors++; $display("FAIL rmid_head: got pc=%h iword=%h fault=%0b expected 0,0,0", deq_pc, deq_iword, deq_fault); end
    steps(6);
    @(negedge clk);
    checks++; if (deq_valid !== 1'b0 || dut.count !== 3'd0) begin errors++; $display("FAIL rmid_stale: got valid=%0b count=%0d expected 0,0", deq_valid, dut.count); end
    step();
    data_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_ce !== 1'b1 || mem_addr !== 23'h0) begin errors++; $display("FAIL rmid_restart: got ce=%0b addr=%h expected ce=1 addr=0", mem_ce, mem_addr); end
  endtask

  initial begin
    test_reset();
    test_prefetch_fill();
    test_redirect_outstanding();
    test_redirect_with_deq();
    test_data_req();
    test_fault();
    test_legacy_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
